cordic_ctrl: RTL and testbench

CORDIC_CTRL -- requirements
Module: cordic_ctrl

---
 rtl/cordic_pkg.sv | 39 +++
 rtl/cordic_addsub.sv | 22 ++
 rtl/cordic_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cordic_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: controller states, arctangent table and gain constant.
// The 16-entry table uses a 2^16 = 360 degree angle scale.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 0.60725 * 2^15, inverse of the accumulated CORDIC gain
    localparam logic [14:0] K = 15'd19898;

    // atan(2^-idx) in angle units
    function automatic logic [15:0] atan_lookup(input logic [3:0] idx);
        logic [15:0] val_s;
        case (idx)
            4'd0:    val_s = 16'd8192;
            4'd1:    val_s = 16'd4836;
            4'd2:    val_s = 16'd2555;
            4'd3:    val_s = 16'd1297;
            4'd4:    val_s = 16'd651;
            4'd5:    val_s = 16'd326;
            4'd6:    val_s = 16'd163;
            4'd7:    val_s = 16'd81;
            4'd8:    val_s = 16'd41;
            4'd9:    val_s = 16'd20;
            4'd10:   val_s = 16'd10;
            4'd11:   val_s = 16'd5;
            4'd12:   val_s = 16'd3;
            4'd13:   val_s = 16'd1;
            4'd14:   val_s = 16'd1;
            4'd15:   val_s = 16'd0;
            default: val_s = 16'd0;
        endcase
        return val_s;
    endfunction

endpackage

// File: rtl/cordic_addsub.sv
// Two's-complement adder/subtractor; sub = 1 computes a - b, otherwise a + b.
module cordic_addsub
    import cordic_pkg::*;
#(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    // Direction-selected add or subtract
    always_comb begin
        if (sub) begin
            sum = a - b;
        end else begin
            sum = a + b;
        end
    end

endmodule

// File: rtl/cordic_ctrl.sv
// Iterative CORDIC engine (rotation / vectoring), one micro-rotation per clock.
// Optional macro CORDIC_GAIN_COMP_EN scales x/y results by K = 0.60725.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] z_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] x_res,
    output logic [DW-1:0] y_res,
    output logic [DW-1:0] z_res
);

    localparam int XW = DW + 2;

    state_t               state_r, state_s;
    logic [3:0]           i_r;
    logic signed [XW-1:0] x_r, y_r;
    logic [DW-1:0]        z_r;
    logic                 mode_r, busy_r, done_r;
    logic [DW-1:0]        x_res_r, y_res_r, z_res_r;

    logic                 load_s, finish_s, busy_s, last_s, d_pos_s;
    logic signed [XW-1:0] x_ext_s, y_ext_s, x_ld_s, y_ld_s;
    logic [DW-1:0]        z_ld_s, z_sum_s, atan_s;
    logic signed [XW-1:0] x_shift_s, y_shift_s, x_sum_s, y_sum_s, x_fin_s, y_fin_s;

    // Clamp the widened x/y back into the signed DW range
    function automatic logic [DW-1:0] sat_dw(input logic signed [XW-1:0] v);
        logic [DW-1:0] r;
        if ((v[XW-1:DW-1] == 3'b000) || (v[XW-1:DW-1] == 3'b111)) begin
            r = v[DW-1:0];
        end else if (v[XW-1]) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // v * K / 2^15 by shift-add; taking the upper bits floors toward -inf
    function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
        logic signed [XW+14:0] acc, ext;
        ext = {{15{v[XW-1]}}, v};
        acc = {(XW+15){1'b0}};
        for (int b = 0; b < 15; b++) begin
            if (K[b]) begin
                acc = acc + (ext <<< b);
            end else begin
                acc = acc;
            end
        end
        return acc[XW+14:15];
    endfunction
`endif

    assign last_s = (i_r == 4'(ITERS - 1));

    // Next-state decode; abort outranks completion on the final iteration
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ITER;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s  = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    state_s = ST_ITER;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s == ST_ITER) || (state_s == ST_DONE);
    end

    // Operand load; vectoring with negative x pre-rotates by 180 degrees
    always_comb begin
        x_ext_s = {{2{x_in[DW-1]}}, x_in};
        y_ext_s = {{2{y_in[DW-1]}}, y_in};
        if (mode && x_in[DW-1]) begin
            x_ld_s = -x_ext_s;
            y_ld_s = -y_ext_s;
            z_ld_s = z_in + {1'b1, {(DW-1){1'b0}}};
        end else begin
            x_ld_s = x_ext_s;
            y_ld_s = y_ext_s;
            z_ld_s = z_in;
        end
    end

    // Shifted cross terms, angle step and rotation direction
    always_comb begin
        x_shift_s = x_r >>> i_r;
        y_shift_s = y_r >>> i_r;
        atan_s    = DW'(atan_lookup(i_r));
        if (mode_r) begin
            d_pos_s = y_r[XW-1];
        end else begin
            d_pos_s = ~z_r[DW-1];
        end
    end

    cordic_addsub #(.W(XW)) u_x (.a(x_r), .b(y_shift_s), .sub(d_pos_s),  .sum(x_sum_s));
    cordic_addsub #(.W(XW)) u_y (.a(y_r), .b(x_shift_s), .sub(~d_pos_s), .sum(y_sum_s));
    cordic_addsub #(.W(DW)) u_z (.a(z_r), .b(atan_s),    .sub(d_pos_s),  .sum(z_sum_s));

    // Optional gain compensation ahead of saturation
    always_comb begin
`ifdef CORDIC_GAIN_COMP_EN
        x_fin_s = gain_comp(x_sum_s);
        y_fin_s = gain_comp(y_sum_s);
`else
        x_fin_s = x_sum_s;
        y_fin_s = y_sum_s;
`endif
    end

    // Controller state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= finish_s;
        end
    end

    // Iteration datapath; results capture the final micro-rotation directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_r     <= 4'd0;
            x_r     <= {XW{1'b0}};
            y_r     <= {XW{1'b0}};
            z_r     <= {DW{1'b0}};
            mode_r  <= 1'b0;
            x_res_r <= {DW{1'b0}};
            y_res_r <= {DW{1'b0}};
            z_res_r <= {DW{1'b0}};
        end else begin
            if (load_s) begin
                x_r    <= x_ld_s;
                y_r    <= y_ld_s;
                z_r    <= z_ld_s;
                mode_r <= mode;
                i_r    <= 4'd0;
            end else if (state_r == ST_ITER) begin
                x_r <= x_sum_s;
                y_r <= y_sum_s;
                z_r <= z_sum_s;
                i_r <= i_r + 4'd1;
            end
            if (finish_s) begin
                x_res_r <= sat_dw(x_fin_s);
                y_res_r <= sat_dw(y_fin_s);
                z_res_r <= z_sum_s;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign x_res = x_res_r;
    assign y_res = y_res_r;
    assign z_res = z_res_r;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Self-checking bench for cordic_ctrl: directed spec vectors plus random operands
// compared against an integer CORDIC reference model.
module tb_cordic_ctrl;

    localparam int DW    = 16;
    localparam int ITERS = 16;

    logic          clk = 1'b0;
    logic          rst, start, mode, abort;
    logic [DW-1:0] x_in, y_in, z_in;
    logic          busy, done;
    logic [DW-1:0] x_res, y_res, z_res;

    int n_cmp  = 0;
    int n_fail = 0;
    int atan_ref [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
    int prev_x = 0, prev_y = 0, prev_z = 0;

    cordic_ctrl #(.ITERS(ITERS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done), .x_res(x_res), .y_res(y_res), .z_res(z_res)
    );

    always #5 clk = ~clk;

    function automatic int w16(longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int sat16(longint v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return int'(v);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic model(input logic m, input int xi, input int yi, input int zi,
                         output int xo, output int yo, output int zo);
        longint x, y, z, xs, ys;
        bit dpos;
        x = xi; y = yi; z = zi;
        if (m && xi < 0) begin
            x = -x; y = -y; z = w16(z + 32768);
        end
        for (int i = 0; i < ITERS; i++) begin
            dpos = m ? (y < 0) : (z >= 0);
            xs = x >>> i;
            ys = y >>> i;
            if (dpos) begin
                x = x - ys; y = y + xs; z = z - atan_ref[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_ref[i];
            end
            z = w16(z);
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x * 19898) >>> 15;
        y = (y * 19898) >>> 15;
`endif
        xo = sat16(x); yo = sat16(y); zo = int'(z);
    endtask

    task automatic run_op(input logic m, input int xi, input int yi, input int zi,
                          output int lat, output int bcnt, output int xr, output int yr, output int zr);
        @(negedge clk);
        start = 1'b1; mode = m;
        x_in = xi[15:0]; y_in = yi[15:0]; z_in = zi[15:0];
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        xr = int'($signed(x_res)); yr = int'($signed(y_res)); zr = int'($signed(z_res));
        for (int g = 0; g < 10 && busy === 1'b1; g++) begin
            bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic op_and_check(input string nm, input logic m, input int xi, input int yi, input int zi,
                                output int xr, output int yr, output int zr);
        int lat, bcnt, ex, ey, ez;
        model(m, xi, yi, zi, ex, ey, ez);
        run_op(m, xi, yi, zi, lat, bcnt, xr, yr, zr);
        n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL %s latency: got %0d expected 17", nm, lat); end
        n_cmp++; if (bcnt !== 17) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected 17", nm, bcnt); end
        n_cmp++; if (xr !== ex) begin n_fail++; $display("FAIL %s x_res: got %0d expected %0d", nm, xr, ex); end
        n_cmp++; if (yr !== ey) begin n_fail++; $display("FAIL %s y_res: got %0d expected %0d", nm, yr, ey); end
        n_cmp++; if (zr !== ez) begin n_fail++; $display("FAIL %s z_res: got %0d expected %0d", nm, zr, ez); end
        prev_x = ex; prev_y = ey; prev_z = ez;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_cmp++; if ({x_res, y_res, z_res} !== 48'd0) begin n_fail++; $display("FAIL reset results: got %h expected 0", {x_res, y_res, z_res}); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_rotation;
        int xr, yr, zr;
`ifdef CORDIC_GAIN_COMP_EN
        op_and_check("rot45", 1'b0, 10000, 0, 8192, xr, yr, zr);
        n_cmp++; if (iabs(xr - 7071) > 4) begin n_fail++; $display("FAIL rot45 x_tol: got %0d expected 7071", xr); end
        n_cmp++; if (iabs(yr - 7071) > 4) begin n_fail++; $display("FAIL rot45 y_tol: got %0d expected 7071", yr); end
`else
        op_and_check("rot0", 1'b0, 10000, 0, 0, xr, yr, zr);
        n_cmp++; if (iabs(xr - 16468) > 4) begin n_fail++; $display("FAIL rot0 x_tol: got %0d expected 16468", xr); end
        n_cmp++; if (iabs(yr) > 4) begin n_fail++; $display("FAIL rot0 y_tol: got %0d expected 0", yr); end
        n_cmp++; if (iabs(w16(zr)) > 4) begin n_fail++; $display("FAIL rot0 z_tol: got %0d expected 0", zr); end
`endif
        for (int k = 0; k < 6; k++) op_and_check("rot_rand", 1'b0, rnd16(), rnd16(), rnd16(), xr, yr, zr);
    endtask

    task automatic test_vectoring;
        int xr, yr, zr;
        op_and_check("vec45", 1'b1, 10000, 10000, 0, xr, yr, zr);
`ifndef CORDIC_GAIN_COMP_EN
        n_cmp++; if (iabs(yr) > 4) begin n_fail++; $display("FAIL vec45 y_tol: got %0d expected 0", yr); end
        n_cmp++; if (iabs(zr - 8192) > 4) begin n_fail++; $display("FAIL vec45 z_tol: got %0d expected 8192", zr); end
        n_cmp++; if (iabs(xr - 23289) > 6) begin n_fail++; $display("FAIL vec45 x_tol: got %0d expected 23289", xr); end
`endif
        op_and_check("vec180", 1'b1, -10000, 0, 0, xr, yr, zr);
`ifndef CORDIC_GAIN_COMP_EN
        n_cmp++; if (iabs(w16(zr + 32768)) > 4) begin n_fail++; $display("FAIL vec180 z_tol: got %0d expected -32768", zr); end
        n_cmp++; if (iabs(xr - 16468) > 4) begin n_fail++; $display("FAIL vec180 x_tol: got %0d expected 16468", xr); end
`endif
        for (int k = 0; k < 6; k++) op_and_check("vec_rand", 1'b1, rnd16(), rnd16(), rnd16(), xr, yr, zr);
    endtask

    task automatic test_saturation;
        int xr, yr, zr;
        op_and_check("sat_pos", 1'b1, 32767, 32767, 0, xr, yr, zr);
        n_cmp++; if (xr !== 32767) begin n_fail++; $display("FAIL sat_pos x_clamp: got %0d expected 32767", xr); end
        op_and_check("sat_neg", 1'b0, -32768, -32768, 0, xr, yr, zr);
`ifndef CORDIC_GAIN_COMP_EN
        n_cmp++; if (xr !== -32768) begin n_fail++; $display("FAIL sat_neg x_clamp: got %0d expected -32768", xr); end
`endif
        op_and_check("vec_minx", 1'b1, -32768, 5, 100, xr, yr, zr);
    endtask

    task automatic test_back_to_back;
        int ax, ay, az, bx, by, bz, e1[3], e2[3];
        int dc[$], rx[$], ry[$], rz[$];
        logic busy18, busy19;
        int d0, d1;
        ax = rnd16(); ay = rnd16(); az = rnd16();
        bx = rnd16(); by = rnd16(); bz = rnd16();
        model(1'b0, ax, ay, az, e1[0], e1[1], e1[2]);
        model(1'b1, bx, by, bz, e2[0], e2[1], e2[2]);
        busy18 = 1'bx; busy19 = 1'bx;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x_in = ax[15:0]; y_in = ay[15:0]; z_in = az[15:0];
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin mode = 1'b1; x_in = bx[15:0]; y_in = by[15:0]; z_in = bz[15:0]; end
            if (c == 20) start = 1'b0;
            if (c == 18) busy18 = busy;
            if (c == 19) busy19 = busy;
            if (done === 1'b1) begin
                dc.push_back(c);
                rx.push_back(int'($signed(x_res))); ry.push_back(int'($signed(y_res))); rz.push_back(int'($signed(z_res)));
            end
        end
        d0 = (dc.size() > 0) ? dc[0] : -1;
        d1 = (dc.size() > 1) ? dc[1] : -1;
        n_cmp++; if (dc.size() !== 2) begin n_fail++; $display("FAIL b2b done_count: got %0d expected 2", dc.size()); end
        n_cmp++; if (d0 !== 17) begin n_fail++; $display("FAIL b2b done1_cycle: got %0d expected 17", d0); end
        n_cmp++; if (d1 !== 35) begin n_fail++; $display("FAIL b2b done2_cycle: got %0d expected 35", d1); end
        n_cmp++; if (busy18 !== 1'b0) begin n_fail++; $display("FAIL b2b gap_busy: got %b expected 0", busy18); end
        n_cmp++; if (busy19 !== 1'b1) begin n_fail++; $display("FAIL b2b restart_busy: got %b expected 1", busy19); end
        if (dc.size() == 2) begin
            n_cmp++; if ({rx[0], ry[0], rz[0]} !== {e1[0], e1[1], e1[2]}) begin n_fail++;
                $display("FAIL b2b op1_res: got %0d %0d %0d expected %0d %0d %0d", rx[0], ry[0], rz[0], e1[0], e1[1], e1[2]); end
            n_cmp++; if ({rx[1], ry[1], rz[1]} !== {e2[0], e2[1], e2[2]}) begin n_fail++;
                $display("FAIL b2b op2_res: got %0d %0d %0d expected %0d %0d %0d", rx[1], ry[1], rz[1], e2[0], e2[1], e2[2]); end
        end
        prev_x = e2[0]; prev_y = e2[1]; prev_z = e2[2];
    endtask

    task automatic test_abort;
        int xr, yr, zr, saw_done;
        op_and_check("pre_abort", 1'b0, 12345, -2222, 3000, xr, yr, zr);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; x_in = 16'd20000; y_in = 16'd7000; z_in = 16'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        saw_done = 0;
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) saw_done++;
            @(negedge clk);
        end
        n_cmp++; if (saw_done !== 0) begin n_fail++; $display("FAIL abort no_done: got %0d pulses expected 0", saw_done); end
        n_cmp++; if ({int'($signed(x_res)), int'($signed(y_res)), int'($signed(z_res))} !== {prev_x, prev_y, prev_z}) begin
            n_fail++; $display("FAIL abort hold: got %0d %0d %0d expected %0d %0d %0d",
                               $signed(x_res), $signed(y_res), $signed(z_res), prev_x, prev_y, prev_z); end
    endtask

    task automatic test_start_abort_idle;
        int ex, ey, ez, c;
        model(1'b0, -7000, 9000, -5000, ex, ey, ez);
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mode = 1'b0; x_in = 16'hE4A8; y_in = 16'd9000; z_in = 16'hEC78;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_abort busy: got %b expected 1", busy); end
        c = 1;
        while (done !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        n_cmp++; if (c !== 17) begin n_fail++; $display("FAIL start_abort latency: got %0d expected 17", c); end
        n_cmp++; if ({int'($signed(x_res)), int'($signed(y_res)), int'($signed(z_res))} !== {ex, ey, ez}) begin
            n_fail++; $display("FAIL start_abort res: got %0d %0d %0d expected %0d %0d %0d",
                               $signed(x_res), $signed(y_res), $signed(z_res), ex, ey, ez); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_iter;
        int xr, yr, zr;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x_in = 16'd5000; y_in = 16'd5000; z_in = 16'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid done: got %b expected 0", done); end
        n_cmp++; if ({x_res, y_res, z_res} !== 48'd0) begin n_fail++; $display("FAIL rst_mid results: got %h expected 0", {x_res, y_res, z_res}); end
        @(negedge clk);
        rst = 1'b0;
        op_and_check("post_rst", 1'b1, 3000, -4000, 0, xr, yr, zr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        x_in = 16'd0; y_in = 16'd0; z_in = 16'd0;
        test_reset();
        test_rotation();
        test_vectoring();
        test_saturation();
        test_back_to_back();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_iter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
